// File: rtl/bitonic_pkg.sv
// Shared helpers for the bitonic sorting network: stage count, stage-to-(phase, step)
// mapping, partner lane and compare direction.
package bitonic_pkg;

  // Largest supported log2 key count.
  localparam int unsigned MaxLog   = 6;
  localparam int unsigned MaxLanes = 1 << MaxLog;

  // Number of compare-exchange stages for 2**l keys.
  function automatic int unsigned stages(int unsigned l);
    return l * (l + 1) / 2;
  endfunction

  // Merge phase (1-based) that flat stage index s belongs to.
  function automatic int unsigned phase_of(int unsigned s);
    int unsigned p;
    p = 1;
    for (int unsigned k = 2; k <= MaxLog; k++) begin
      if (s >= stages(k - 1)) p = k;
    end
    return p;
  endfunction

  // Sub-step d (pair distance 2**d) of flat stage index s; counts down within a phase.
  function automatic int unsigned step_of(int unsigned s);
    int unsigned p;
    p = phase_of(s);
    return p - 1 - (s - stages(p - 1));
  endfunction

  function automatic int unsigned partner(int unsigned i, int unsigned d);
    return i ^ (1 << d);
  endfunction

  // 1 when the lower lane of the pair must end up holding the larger key.
  function automatic bit pair_desc(int unsigned i, int unsigned p, int unsigned l,
                                   int unsigned asc);
    bit desc;
    desc = (p < l) ? bit'((i >> p) & 1) : 1'b0;
    return desc ^ (asc == 0);
  endfunction

endpackage

// File: rtl/bitonic_sorter_if.sv
// Key-vector interface between the AXI peripheral shell (master) and the sorter (slave).
interface bitonic_sorter_if #(
  parameter int unsigned LOG_INPUT_NUM = 4,
  parameter int unsigned DATAWIDTH     = 32
);
  localparam int unsigned Width = DATAWIDTH * (1 << LOG_INPUT_NUM);

  logic             x_valid;
  logic [Width-1:0] x;
  logic [Width-1:0] y;
  logic             y_valid;

  modport master (output x_valid, output x, input y, input y_valid);
  modport slave  (input x_valid, input x, output y, output y_valid);
endinterface

// File: rtl/bitonic_cmp_swap.sv
// Combinational compare-exchange of two keys; swaps only when strictly out of order,
// so equal keys pass straight through.
module bitonic_cmp_swap #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned SIGNED    = 0,
  parameter bit          DESC      = 1'b0
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic [DATAWIDTH-1:0] a_o,
  output logic [DATAWIDTH-1:0] b_o
);

  logic a_gt_b;
  logic b_gt_a;
  logic swap;

  // Order the pair: a_o takes the min (ascending) or the max (descending).
  always_comb begin
    if (SIGNED != 0) begin
      a_gt_b = $signed(a_i) > $signed(b_i);
      b_gt_a = $signed(b_i) > $signed(a_i);
    end else begin
      a_gt_b = a_i > b_i;
      b_gt_a = b_i > a_i;
    end
    swap = DESC ? b_gt_a : a_gt_b;
    a_o  = swap ? b_i : a_i;
    b_o  = swap ? a_i : b_i;
  end

endmodule

// File: rtl/bitonic_sorter.sv
// Fully pipelined bitonic sorter: one key vector per cycle, one registered
// compare-exchange stage per network step, valid bit shifted alongside.
// Optional macro BITONIC_OUT_REG_EN adds one output register stage on y/y_valid.
module bitonic_sorter
  import bitonic_pkg::*;
#(
  parameter int unsigned LOG_INPUT_NUM = 4,
  parameter int unsigned DATAWIDTH     = 32,
  parameter int unsigned SIGNED        = 0,
  parameter int unsigned ASCENDING     = 1
) (
  input  logic             clk,
  input  logic             rst,
  bitonic_sorter_if.slave  bus
);

  localparam int unsigned N = 1 << LOG_INPUT_NUM;
  localparam int unsigned S = stages(LOG_INPUT_NUM);
  localparam int unsigned W = DATAWIDTH * N;

  // stage_in[0] is the raw input; stage_in[s+1] is the register after stage s.
  logic [W-1:0] stage_in [S+1];
  logic [S-1:0] valid_q;
  logic [S-1:0] valid_d;

  assign stage_in[0] = bus.x;

  for (genvar s = 0; s < S; s++) begin : gen_stage
    localparam int unsigned P = phase_of(s);
    localparam int unsigned D = step_of(s);

    logic [W-1:0] net_d;
    logic [W-1:0] data_q;

    for (genvar i = 0; i < N; i++) begin : gen_lane
      if (((i >> D) & 1) == 0) begin : gen_pair
        localparam int unsigned J = partner(i, D);
        bitonic_cmp_swap #(
          .DATAWIDTH (DATAWIDTH),
          .SIGNED    (SIGNED),
          .DESC      (pair_desc(i, P, LOG_INPUT_NUM, ASCENDING))
        ) u_cmp_swap (
          .a_i (stage_in[s][DATAWIDTH*i +: DATAWIDTH]),
          .b_i (stage_in[s][DATAWIDTH*J +: DATAWIDTH]),
          .a_o (net_d[DATAWIDTH*i +: DATAWIDTH]),
          .b_o (net_d[DATAWIDTH*J +: DATAWIDTH])
        );
      end
    end

    // Stage register; loads every cycle, valid or not.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) data_q <= '0;
      else      data_q <= net_d;
    end

    assign stage_in[s+1] = data_q;
  end

  // Next state of the valid shift chain.
  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = bus.x_valid;
  end

  // Valid shift chain, cleared by reset so in-flight vectors are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

`ifdef BITONIC_OUT_REG_EN
  logic [W-1:0] y_q;
  logic         y_valid_q;

  // Extra output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= stage_in[S];
      y_valid_q <= valid_q[S-1];
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
`else
  assign bus.y       = stage_in[S];
  assign bus.y_valid = valid_q[S-1];
`endif

endmodule

// File: tb/tb_bitonic_sorter.sv
// Self-checking bench: default (unsigned ascending) and signed descending sorters fed the
// same stimulus, checked every cycle against a sort-and-delay reference model.
module tb_bitonic_sorter;

  localparam int unsigned L  = 4;
  localparam int unsigned N  = 1 << L;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = N * DW;
`ifdef BITONIC_OUT_REG_EN
  localparam int unsigned Lat = L * (L + 1) / 2 + 1;
`else
  localparam int unsigned Lat = L * (L + 1) / 2;
`endif

  logic         clk;
  logic         rst;
  logic         x_valid;
  logic [W-1:0] x;

  int unsigned n_tests;
  int unsigned n_fail;

  // Reference pipeline: expected valid and sorted vectors, index Lat-1 is the output.
  bit           mv    [Lat];
  logic [W-1:0] my_a  [Lat];
  logic [W-1:0] my_sd [Lat];

  bitonic_sorter_if #(.LOG_INPUT_NUM(L), .DATAWIDTH(DW)) bus_a ();
  bitonic_sorter_if #(.LOG_INPUT_NUM(L), .DATAWIDTH(DW)) bus_sd ();

  assign bus_a.x        = x;
  assign bus_a.x_valid  = x_valid;
  assign bus_sd.x       = x;
  assign bus_sd.x_valid = x_valid;

  bitonic_sorter #(
    .LOG_INPUT_NUM (L),
    .DATAWIDTH     (DW),
    .SIGNED        (0),
    .ASCENDING     (1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bitonic_sorter #(
    .LOG_INPUT_NUM (L),
    .DATAWIDTH     (DW),
    .SIGNED        (1),
    .ASCENDING     (0)
  ) u_dut_sd (
    .clk (clk),
    .rst (rst),
    .bus (bus_sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit key_less(logic [DW-1:0] p, logic [DW-1:0] q, bit sgn);
    return sgn ? ($signed(p) < $signed(q)) : (p < q);
  endfunction

  // Plain insertion sort of the lanes.
  function automatic logic [W-1:0] sort_vec(logic [W-1:0] v, bit sgn, bit asc);
    logic [DW-1:0] k [N];
    logic [DW-1:0] t;
    logic [W-1:0]  r;
    for (int j = 0; j < N; j++) k[j] = v[DW*j +: DW];
    for (int a = 1; a < N; a++) begin
      for (int b = a; b > 0; b--) begin
        if (asc ? key_less(k[b], k[b-1], sgn) : key_less(k[b-1], k[b], sgn)) begin
          t = k[b]; k[b] = k[b-1]; k[b-1] = t;
        end
      end
    end
    for (int j = 0; j < N; j++) r[DW*j +: DW] = k[j];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int j = 0; j < N; j++) r[DW*j +: DW] = $urandom;
    return r;
  endfunction

  // One clock: advance the model at the rising edge, check both DUTs at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < Lat; k++) begin
        mv[k] = 1'b0; my_a[k] = '0; my_sd[k] = '0;
      end
    end else begin
      for (int k = Lat - 1; k > 0; k--) begin
        mv[k] = mv[k-1]; my_a[k] = my_a[k-1]; my_sd[k] = my_sd[k-1];
      end
      mv[0]    = x_valid;
      my_a[0]  = sort_vec(x, 1'b0, 1'b1);
      my_sd[0] = sort_vec(x, 1'b1, 1'b0);
    end
    @(negedge clk);
    if (!rst) begin
      check_eq("rst_vld_a", W'(bus_a.y_valid), '0);
      check_eq("rst_y_a", bus_a.y, '0);
      check_eq("rst_vld_sd", W'(bus_sd.y_valid), '0);
      check_eq("rst_y_sd", bus_sd.y, '0);
    end else begin
      check_eq("vld_a", W'(bus_a.y_valid), W'(mv[Lat-1]));
      check_eq("vld_sd", W'(bus_sd.y_valid), W'(mv[Lat-1]));
      if (mv[Lat-1]) begin
        check_eq("y_a", bus_a.y, my_a[Lat-1]);
        check_eq("y_sd", bus_sd.y, my_sd[Lat-1]);
      end
    end
  endtask

  // Single valid vector, then wait until its result is on y.
  task automatic apply_one(input logic [W-1:0] v);
    x = v; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    repeat (Lat - 1) tick();
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] exp_v;
    int unsigned  cnt;

    n_tests = 0;
    n_fail  = 0;
    for (int k = 0; k < Lat; k++) begin
      mv[k] = 1'b0; my_a[k] = '0; my_sd[k] = '0;
    end
    rst = 1'b0; x_valid = 1'b1; x = rand_vec();

    // Reset held with x_valid high, then measure first-output latency.
    repeat (3) tick();
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      cnt++;
      x_valid = 1'b0;
      if (bus_a.y_valid) break;
    end
    check_eq("latency", W'(cnt), W'(Lat));
    repeat (Lat) tick();

    // Reversed keys 15..0 sort to 0..15.
    for (int j = 0; j < N; j++) v[DW*j +: DW] = DW'(N - 1 - j);
    for (int j = 0; j < N; j++) exp_v[DW*j +: DW] = DW'(j);
    apply_one(v);
    check_eq("reverse_asc", bus_a.y, exp_v);

    // Duplicates and extremes.
    v = '0;
    for (int j = 6; j < N; j++) v[DW*j +: DW] = $urandom_range(32'hFFFF_FFFE, 0);
    v[DW*0 +: DW] = 32'd5; v[DW*1 +: DW] = 32'd5; v[DW*2 +: DW] = 32'hFFFF_FFFF;
    v[DW*3 +: DW] = 32'd0; v[DW*4 +: DW] = 32'd5; v[DW*5 +: DW] = 32'd1;
    apply_one(v);
    exp_v = bus_a.y;
    check_eq("dup_top_lane", W'(exp_v[DW*(N-1) +: DW]), W'(32'hFFFF_FFFF));

    // Signed descending extremes.
    for (int j = 3; j < N; j++) v[DW*j +: DW] = DW'($urandom_range(2000, 0)) - 32'd1000;
    v[DW*0 +: DW] = 32'hFFFF_FFFF; v[DW*1 +: DW] = 32'h8000_0000;
    v[DW*2 +: DW] = 32'h7FFF_FFFF;
    apply_one(v);
    exp_v = bus_sd.y;
    check_eq("sd_lane0", W'(exp_v[DW*0 +: DW]), W'(32'h7FFF_FFFF));
    check_eq("sd_lane15", W'(exp_v[DW*(N-1) +: DW]), W'(32'h8000_0000));

    // Streaming with x_valid held high.
    x_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      x = rand_vec();
      tick();
    end

    // One-cycle gap in x_valid gives exactly one low y_valid cycle.
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      x = rand_vec();
      x_valid = (c != 0);
      tick();
      if (!bus_a.y_valid) cnt++;
    end
    check_eq("gap_lows", W'(cnt), W'(1));
    x_valid = 1'b0;
    repeat (Lat) tick();

    // Mid-stream reset with 5 vectors in flight.
    x_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      x = rand_vec();
      tick();
    end
    x_valid = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < Lat + 3; c++) begin
      tick();
      if (bus_a.y_valid || bus_sd.y_valid) cnt++;
    end
    check_eq("stale_valid", W'(cnt), '0);

    // Random vectors after the reset still sort correctly.
    for (int c = 0; c < 4; c++) apply_one(rand_vec());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
